// File: rtl/servo_recarga_pkg.sv
// Shared definitions for the reload-servo sequencer: FSM state encoding,
// default timing and pulse-width constants, and width helpers.
package servo_recarga_pkg;

  typedef enum logic [1:0] {
    INICIAL = 2'd0,
    CARGA   = 2'd1,
    RETORNO = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam int unsigned DEF_PWM_PERIOD = 1_000_000;
  localparam int unsigned DEF_PW_REPOUSO = 50_000;
  localparam int unsigned DEF_PW_CARGA   = 100_000;
  localparam int unsigned DEF_T_CARGA    = 25_000_000;
  localparam int unsigned DEF_T_RETORNO  = 25_000_000;
  localparam int unsigned DEF_NREC_W     = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for values 0..v-1; never collapses to zero bits.
  function automatic int unsigned largura_bits(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/gerador_pwm_servo.sv
// Servo PWM generator: free-running period counter with a pulse-width
// register that only takes a new value at the period boundary.
module gerador_pwm_servo
  import servo_recarga_pkg::*;
#(
  parameter  int unsigned PWM_PERIOD = DEF_PWM_PERIOD,
  parameter  int unsigned PW_INICIAL = DEF_PW_REPOUSO,
  localparam int unsigned CNT_W      = largura_bits(PWM_PERIOD)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] largura,
  output logic             pwm
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] largura_q;
  logic             pwm_q;
  logic             fim_periodo;

  assign fim_periodo = (cnt_q == CNT_W'(PWM_PERIOD - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (fim_periodo) cnt_d = '0;
  end

  // Width is sampled only on the last count, so a pulse in flight is never
  // truncated or stretched by a position change.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      largura_q <= CNT_W'(PW_INICIAL);
      pwm_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (fim_periodo) largura_q <= largura;
      pwm_q <= (cnt_q < largura_q);
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/servo_recarga_seq.sv
// Reload sequencer: runs N load/return strokes on the loading servo with
// abort and completion handshake. Optional debug ports: SERVO_RECARGA_DEBUG_EN.
module servo_recarga_seq
  import servo_recarga_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = DEF_PWM_PERIOD,
  parameter int unsigned PW_REPOUSO = DEF_PW_REPOUSO,
  parameter int unsigned PW_CARGA   = DEF_PW_CARGA,
  parameter int unsigned T_CARGA    = DEF_T_CARGA,
  parameter int unsigned T_RETORNO  = DEF_T_RETORNO,
  parameter int unsigned NREC_W     = DEF_NREC_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [NREC_W-1:0] quantidade,
  input  logic              abortar,
  output logic              pwm,
  output logic              ocupado,
  output logic              recarga_pulso,
  output logic              fim,
  output logic              abortado,
  output logic [NREC_W-1:0] restantes
`ifdef SERVO_RECARGA_DEBUG_EN
  ,
  output logic [1:0]        db_estado,
  output logic              db_posicao
`endif
);

  localparam int unsigned TMR_W = largura_bits(max_u(T_CARGA, T_RETORNO));
  localparam int unsigned PWM_W = largura_bits(PWM_PERIOD);

  estado_t           estado_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [NREC_W-1:0] restantes_q;
  logic              ocupado_q;
  logic              pulso_q;
  logic              fim_q;
  logic              abortado_q;
  logic              abort_flag_q;
  logic              cancela_q;
  logic [PWM_W-1:0]  largura_d;
  logic              fim_carga;
  logic              fim_retorno;

  assign fim_carga   = (tmr_q == TMR_W'(T_CARGA - 1));
  assign fim_retorno = (tmr_q == TMR_W'(T_RETORNO - 1));

  always_comb begin
    // NOTE: assign a default before any condition so no path leaves the
    // signal unassigned; otherwise synthesis infers a latch.
    largura_d = PWM_W'(PW_REPOUSO);
    if (estado_q == CARGA) largura_d = PWM_W'(PW_CARGA);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the value from before this clock edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= INICIAL;
      tmr_q        <= '0;
      restantes_q  <= '0;
      ocupado_q    <= 1'b0;
      pulso_q      <= 1'b0;
      fim_q        <= 1'b0;
      abortado_q   <= 1'b0;
      abort_flag_q <= 1'b0;
      cancela_q    <= 1'b0;
    end else begin
      pulso_q    <= 1'b0;
      fim_q      <= 1'b0;
      abortado_q <= 1'b0;
      case (estado_q)
        INICIAL: begin
          if (iniciar) begin
            ocupado_q <= 1'b1;
            tmr_q     <= '0;
            if (quantidade != '0) begin
              restantes_q <= quantidade;
              estado_q    <= CARGA;
            end else begin
              fim_q    <= 1'b1;
              estado_q <= FIM;
            end
          end
        end
        CARGA: begin
          // An aborted stroke still returns to rest but is not counted.
          if (abortar) begin
            abort_flag_q <= 1'b1;
            cancela_q    <= 1'b1;
            tmr_q        <= '0;
            estado_q     <= RETORNO;
          end else if (fim_carga) begin
            tmr_q    <= '0;
            estado_q <= RETORNO;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        RETORNO: begin
          if (abortar) abort_flag_q <= 1'b1;
          if (fim_retorno) begin
            tmr_q     <= '0;
            cancela_q <= 1'b0;
            if (!cancela_q) begin
              pulso_q     <= 1'b1;
              restantes_q <= restantes_q - NREC_W'(1);
            end
            if (restantes_q == NREC_W'(1) || abort_flag_q || abortar) begin
              fim_q      <= 1'b1;
              abortado_q <= abort_flag_q | abortar;
              estado_q   <= FIM;
            end else begin
              estado_q <= CARGA;
            end
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        FIM: begin
          abort_flag_q <= 1'b0;
          ocupado_q    <= 1'b0;
          estado_q     <= INICIAL;
        end
      endcase
    end
  end

  gerador_pwm_servo #(
    .PWM_PERIOD (PWM_PERIOD),
    .PW_INICIAL (PW_REPOUSO)
  ) u_pwm (
    .clock   (clock),
    .reset   (reset),
    .largura (largura_d),
    .pwm     (pwm)
  );

  assign ocupado       = ocupado_q;
  assign recarga_pulso = pulso_q;
  assign fim           = fim_q;
  assign abortado      = abortado_q;
  assign restantes     = restantes_q;

`ifdef SERVO_RECARGA_DEBUG_EN
  assign db_estado  = estado_q;
  assign db_posicao = (estado_q == CARGA);
`endif

endmodule

// File: tb/tb_servo_recarga_seq.sv
// Directed bench for servo_recarga_seq: scoreboard of expected stroke and
// completion events plus PWM pulse-width/period measurements.
module tb_servo_recarga_seq;

  localparam int PER = 100;
  localparam int PWR = 5;
  localparam int PWC = 10;
  localparam int TC  = 20;
  localparam int TR  = 30;
  localparam int NW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iniciar = 1'b0;
  logic          abortar = 1'b0;
  logic [NW-1:0] quantidade = '0;
  logic          pwm, ocupado, recarga_pulso, fim, abortado;
  logic [NW-1:0] restantes;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int fim_cnt = 0;

  typedef struct {
    bit            is_fim;
    int            when;
    logic [NW-1:0] rest;
    logic          abt;
  } ev_t;

  ev_t sb[$];

  servo_recarga_seq #(
    .PWM_PERIOD (PER),
    .PW_REPOUSO (PWR),
    .PW_CARGA   (PWC),
    .T_CARGA    (TC),
    .T_RETORNO  (TR),
    .NREC_W     (NW)
  ) dut (
    .clock         (clk),
    .reset         (rst),
    .iniciar       (iniciar),
    .quantidade    (quantidade),
    .abortar       (abortar),
    .pwm           (pwm),
    .ocupado       (ocupado),
    .recarga_pulso (recarga_pulso),
    .fim           (fim),
    .abortado      (abortado),
    .restantes     (restantes)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ev(input bit is_fim, input int when, input logic [NW-1:0] rest,
                         input logic abt);
    ev_t e;
    e.is_fim = is_fim;
    e.when   = when;
    e.rest   = rest;
    e.abt    = abt;
    sb.push_back(e);
  endtask

  task automatic consume(input bit is_fim);
    ev_t e;
    check("sb_event_expected", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check(is_fim ? "evt_kind_fim" : "evt_kind_pulse", is_fim, e.is_fim);
      check("evt_cycle", cyc, e.when);
      check("evt_restantes", restantes, e.rest);
      if (is_fim) check("evt_abortado", abortado, e.abt);
    end
  endtask

  // Output monitor: every stroke pulse and completion pulse is matched in order.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (recarga_pulso === 1'b1) consume(1'b0);
      if (fim === 1'b1) begin
        fim_cnt++;
        consume(1'b1);
      end
    end
  end

  task automatic start_seq(input logic [NW-1:0] q);
    iniciar    = 1'b1;
    quantidade = q;
    @(negedge clk);
    iniciar = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ocupado === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rise(output int rise, output bit ok);
    int n;
    n = 0;
    while (pwm === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    while (pwm !== 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    ok   = (pwm === 1'b1);
    rise = cyc;
  endtask

  task automatic pulse_len(output int len);
    len = 0;
    while (pwm === 1'b1 && len < 200) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    int  a, r0, r1, r2, r3, len, n0;
    bit  ok;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ocupado", ocupado, 0);
    check("rst_restantes", restantes, 0);
    check("rst_pwm", pwm, 0);
    check("rst_fim", fim, 0);
    check("rst_pulso", recarga_pulso, 0);
    check("rst_abortado", abortado, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ocupado", ocupado, 0);

    // Three strokes
    a = cyc + 1;
    push_ev(1'b0, a + 50, 4'd2, 1'b0);
    push_ev(1'b0, a + 100, 4'd1, 1'b0);
    push_ev(1'b0, a + 150, 4'd0, 1'b0);
    push_ev(1'b1, a + 150, 4'd0, 1'b0);
    start_seq(4'd3);
    check("t1_ocupado_first", ocupado, 1);
    check("t1_restantes_first", restantes, 3);
    wait_idle();
    check("t1_busy_cycles", cyc - a, 151);
    check("t1_sb_drained", sb.size(), 0);

    // Start requests during a sequence are ignored
    a = cyc + 1;
    push_ev(1'b0, a + 50, 4'd1, 1'b0);
    push_ev(1'b0, a + 100, 4'd0, 1'b0);
    push_ev(1'b1, a + 100, 4'd0, 1'b0);
    start_seq(4'd2);
    repeat (9) @(negedge clk);
    start_seq(4'd7);
    while (cyc < a + 30) @(negedge clk);
    start_seq(4'd7);
    check("t6_restantes_kept", restantes, 2);
    wait_idle();
    check("t6_busy_cycles", cyc - a, 101);
    a = cyc + 1;
    push_ev(1'b0, a + 50, 4'd0, 1'b0);
    push_ev(1'b1, a + 50, 4'd0, 1'b0);
    start_seq(4'd1);
    wait_idle();
    check("t6_fresh_busy_cycles", cyc - a, 51);

    // Zero strokes
    a = cyc + 1;
    push_ev(1'b1, a, 4'd0, 1'b0);
    start_seq(4'd0);
    check("t2_ocupado", ocupado, 1);
    wait_idle();
    check("t2_busy_cycles", cyc - a, 1);

    // Abort in CARGA of stroke 2 (timer = 10)
    a = cyc + 1;
    push_ev(1'b0, a + 50, 4'd4, 1'b0);
    push_ev(1'b1, a + 91, 4'd4, 1'b1);
    start_seq(4'd5);
    while (cyc < a + 60) @(negedge clk);
    abortar = 1'b1;
    @(negedge clk);
    abortar = 1'b0;
    wait_idle();
    check("t3_busy_cycles", cyc - a, 92);

    // Abort during RETORNO: the current return still counts
    a = cyc + 1;
    push_ev(1'b0, a + 50, 4'd2, 1'b0);
    push_ev(1'b1, a + 50, 4'd2, 1'b1);
    start_seq(4'd3);
    while (cyc < a + 30) @(negedge clk);
    abortar = 1'b1;
    @(negedge clk);
    abortar = 1'b0;
    wait_idle();
    check("t3b_busy_cycles", cyc - a, 51);

    // PWM: position change during a pulse does not stretch it
    wait_rise(r0, ok);
    check("t4_rise0_found", ok, 1);
    a = cyc + 1;
    push_ev(1'b0, a + 50, 4'd0, 1'b0);
    push_ev(1'b1, a + 50, 4'd0, 1'b0);
    iniciar    = 1'b1;
    quantidade = 4'd1;
    len = 1;
    @(negedge clk);
    iniciar = 1'b0;
    while (pwm === 1'b1 && len < 200) begin
      len++;
      @(negedge clk);
    end
    check("t4_len_during_carga", len, PWR);
    wait_rise(r1, ok);
    check("t4_rise1_found", ok, 1);
    check("t4_period_1", r1 - r0, PER);
    pulse_len(len);
    check("t4_len_rest", len, PWR);
    // CARGA spans the period boundary: next pulse is the load width
    while (cyc < r1 + 89) @(negedge clk);
    a = cyc + 1;
    push_ev(1'b0, a + 50, 4'd0, 1'b0);
    push_ev(1'b1, a + 50, 4'd0, 1'b0);
    start_seq(4'd1);
    wait_rise(r2, ok);
    check("t4_rise2_found", ok, 1);
    check("t4_period_2", r2 - r1, PER);
    pulse_len(len);
    check("t4_len_carga", len, PWC);
    wait_rise(r3, ok);
    check("t4_rise3_found", ok, 1);
    check("t4_period_3", r3 - r2, PER);
    pulse_len(len);
    check("t4_len_back_to_rest", len, PWR);
    wait_idle();
    check("t4_sb_drained", sb.size(), 0);

    // Reset during RETORNO of stroke 2
    a = cyc + 1;
    push_ev(1'b0, a + 50, 4'd2, 1'b0);
    start_seq(4'd3);
    while (cyc < a + 80) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_ocupado", ocupado, 0);
    check("t5_restantes", restantes, 0);
    check("t5_pwm", pwm, 0);
    check("t5_fim", fim, 0);
    rst = 1'b0;
    n0 = fim_cnt;
    repeat (200) @(negedge clk);
    check("t5_no_fim", fim_cnt - n0, 0);
    check("t5_idle", ocupado, 0);

    check("final_sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
